// File: rtl/raizing_snd_pkg.sv
// Shared constants, overwrite-policy encoding and width helpers for the sound mailbox.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package raizing_snd_pkg;

    localparam int DEF_CMD_CH = 4;
    localparam int DEF_RPL_CH = 2;
    localparam int DEF_DW     = 8;

    // Policy applied when main writes into a full command channel.
    typedef enum logic {
        OVF_DROP    = 1'b0,
        OVF_REPLACE = 1'b1
    } ovf_policy_e;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Select width that never collapses to zero bits, so a single-entry bank still has a port.
    function automatic int sel_w(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/raizing_latch_fifo.sv
// Single command channel: small FIFO with full/pending flags and a sticky overflow bit.
// Latency: count, flags and overflow update one cycle after the strobe; head data is read from storage.
// Backpressure: none; a write into a full FIFO replaces the newest entry or is dropped, and sets overflow.
module raizing_latch_fifo
    import raizing_snd_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int DEPTH     = 1,
    parameter int OVERWRITE = int'(OVF_REPLACE)
) (
    input  logic          core_clk,
    input  logic          arst_n,
    input  logic          wr_vld,
    input  logic [DW-1:0] wr_dat,
    input  logic          rd_vld,
    output logic [DW-1:0] head_dat,
    output logic          rd_ok,
    output logic          wr_acc,
    output logic          full,
    output logic          pend,
    input  logic          ovf_clr,
    output logic          ovf
);

    localparam int PW      = sel_w(DEPTH);
    localparam int CW      = clog2(DEPTH) + 1;
    localparam bit REPLACE = (OVERWRITE == int'(OVF_REPLACE));

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr_prev;
    logic [CW-1:0] count;
    logic          push;
    logic          repl;
    logic          ovf_set;

    // Pointers wrap modulo DEPTH; the explicit compare also covers DEPTH=1.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full      = (count == CW'(DEPTH));
    assign pend      = (count != '0);
    assign rd_ok     = rd_vld && pend;
    // A same-cycle pop frees a slot, so a write into a full FIFO is still accepted.
    assign push      = wr_vld && (!full || rd_ok);
    assign ovf_set   = wr_vld && full && !rd_ok;
    assign repl      = ovf_set && REPLACE;
    assign wr_acc    = push || repl;
    assign wptr_prev = (wptr == '0) ? PW'(DEPTH - 1) : wptr - PW'(1);
    assign head_dat  = mem[rptr];

    // Pointer, occupancy and sticky overflow state; overflow set wins over clear.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push) begin
                wptr <= ptr_inc(wptr);
            end
            if (rd_ok) begin
                rptr <= ptr_inc(rptr);
            end
            if (push && !rd_ok) begin
                count <= count + CW'(1);
            end else if (rd_ok && !push) begin
                count <= count - CW'(1);
            end
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    // Storage: enqueue at the write pointer, or overwrite the newest entry when full.
    always_ff @(posedge core_clk) begin
        if (push) begin
            mem[wptr] <= wr_dat;
        end else if (repl) begin
            mem[wptr_prev] <= wr_dat;
        end
    end

endmodule

// File: rtl/raizing_snd_latch_bank.sv
// Main/sound CPU mailbox: command FIFOs to sound, reply registers to main, NMI pulse and IRQ level.
// Latency: one cycle from every strobe to the affected output; no input-to-output combinational path.
// Backpressure: none; full channels report M_FULL and overflow via OVF, reply writes always land.
module raizing_snd_latch_bank
    import raizing_snd_pkg::*;
#(
    parameter int                CMD_CH    = DEF_CMD_CH,
    parameter int                RPL_CH    = DEF_RPL_CH,
    parameter int                DW        = DEF_DW,
    parameter int                DEPTH     = 1,
    parameter int                OVERWRITE = int'(OVF_REPLACE),
    parameter int                NMI_LEN   = 16,
    parameter logic [CMD_CH-1:0] NMI_MASK  = '1
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      M_WE,
    input  logic [sel_w(CMD_CH)-1:0]  M_WSEL,
    input  logic [DW-1:0]             M_DIN,
    input  logic                      M_RE,
    input  logic [sel_w(RPL_CH)-1:0]  M_RSEL,
    output logic [DW-1:0]             M_DOUT,
    output logic [CMD_CH-1:0]         M_FULL,
    output logic [RPL_CH-1:0]         M_RNEW,
    input  logic                      S_RE,
    input  logic [sel_w(CMD_CH)-1:0]  S_RSEL,
    output logic [DW-1:0]             S_DOUT,
    input  logic                      S_WE,
    input  logic [sel_w(RPL_CH)-1:0]  S_WSEL,
    input  logic [DW-1:0]             S_DIN,
    output logic [CMD_CH-1:0]         S_PEND,
    output logic [CMD_CH-1:0]         OVF,
    input  logic [CMD_CH-1:0]         OVF_CLR,
    output logic                      NMI,
    output logic                      IRQ
);

    localparam int CSW = sel_w(CMD_CH);
    localparam int RSW = sel_w(RPL_CH);
    localparam int NW  = clog2(NMI_LEN + 1);

    logic [DW-1:0]     head [CMD_CH];
    logic [CMD_CH-1:0] rd_ok;
    logic [CMD_CH-1:0] wr_acc;
    logic [DW-1:0]     rpl  [RPL_CH];
    logic [NW-1:0]     nmi_cnt;
    logic              nmi_trig;

    for (genvar i = 0; i < CMD_CH; i++) begin : g_ch
        raizing_latch_fifo #(
            .DW        (DW),
            .DEPTH     (DEPTH),
            .OVERWRITE (OVERWRITE)
        ) u_fifo (
            .core_clk (CLK),
            .arst_n   (RESET_N),
            .wr_vld   (M_WE && (M_WSEL == CSW'(i))),
            .wr_dat   (M_DIN),
            .rd_vld   (S_RE && (S_RSEL == CSW'(i))),
            .head_dat (head[i]),
            .rd_ok    (rd_ok[i]),
            .wr_acc   (wr_acc[i]),
            .full     (M_FULL[i]),
            .pend     (S_PEND[i]),
            .ovf_clr  (OVF_CLR[i]),
            .ovf      (OVF[i])
        );
    end

    // Popped data register; an empty-channel pop leaves the previous value in place.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            S_DOUT <= '0;
        end else if (|rd_ok) begin
            S_DOUT <= head[S_RSEL];
        end
    end

    // Reply registers; a same-cycle sound write keeps the new-data flag set over a main read.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int j = 0; j < RPL_CH; j++) begin
                rpl[j] <= '0;
            end
            M_RNEW <= '0;
        end else begin
            for (int j = 0; j < RPL_CH; j++) begin
                if (S_WE && (S_WSEL == RSW'(j))) begin
                    rpl[j]    <= S_DIN;
                    M_RNEW[j] <= 1'b1;
                end else if (M_RE && (M_RSEL == RSW'(j))) begin
                    M_RNEW[j] <= 1'b0;
                end
            end
        end
    end

    // Main reply read register; it captures the value held before any same-cycle sound write.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            M_DOUT <= '0;
        end else if (M_RE && (int'(M_RSEL) < RPL_CH)) begin
            M_DOUT <= rpl[M_RSEL];
        end
    end

    assign nmi_trig = |(wr_acc & NMI_MASK);

    // NMI down-counter; a retrigger reloads it so the pulse stretches without a gap.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            nmi_cnt <= '0;
        end else if (nmi_trig) begin
            nmi_cnt <= NW'(NMI_LEN);
        end else if (nmi_cnt != '0) begin
            nmi_cnt <= nmi_cnt - NW'(1);
        end
    end

    assign NMI = (nmi_cnt != '0);
    assign IRQ = |S_PEND;

endmodule

// File: tb/tb_raizing_snd_latch_bank.sv
module tb_raizing_snd_latch_bank;

    // Instance 0: defaults (DEPTH=1, replace on full). Instance 1: DEPTH=4, drop on full.
    localparam int NLEN = 16;

    logic       clk;
    logic       rst_n;
    logic       m_we;
    logic [1:0] m_wsel;
    logic [7:0] m_din;
    logic       m_re;
    logic [0:0] m_rsel;
    logic       s_re;
    logic [1:0] s_rsel;
    logic       s_we;
    logic [0:0] s_wsel;
    logic [7:0] s_din;
    logic [3:0] ovf_clr;

    logic [7:0] m_dout [2];
    logic [3:0] m_full [2];
    logic [1:0] m_rnew [2];
    logic [7:0] s_dout [2];
    logic [3:0] s_pend [2];
    logic [3:0] ovf    [2];
    logic       nmi    [2];
    logic       irq    [2];

    raizing_snd_latch_bank u_d1 (
        .CLK(clk), .RESET_N(rst_n),
        .M_WE(m_we), .M_WSEL(m_wsel), .M_DIN(m_din),
        .M_RE(m_re), .M_RSEL(m_rsel), .M_DOUT(m_dout[0]),
        .M_FULL(m_full[0]), .M_RNEW(m_rnew[0]),
        .S_RE(s_re), .S_RSEL(s_rsel), .S_DOUT(s_dout[0]),
        .S_WE(s_we), .S_WSEL(s_wsel), .S_DIN(s_din),
        .S_PEND(s_pend[0]), .OVF(ovf[0]), .OVF_CLR(ovf_clr),
        .NMI(nmi[0]), .IRQ(irq[0])
    );

    raizing_snd_latch_bank #(.DEPTH(4), .OVERWRITE(0)) u_d4 (
        .CLK(clk), .RESET_N(rst_n),
        .M_WE(m_we), .M_WSEL(m_wsel), .M_DIN(m_din),
        .M_RE(m_re), .M_RSEL(m_rsel), .M_DOUT(m_dout[1]),
        .M_FULL(m_full[1]), .M_RNEW(m_rnew[1]),
        .S_RE(s_re), .S_RSEL(s_rsel), .S_DOUT(s_dout[1]),
        .S_WE(s_we), .S_WSEL(s_wsel), .S_DIN(s_din),
        .S_PEND(s_pend[1]), .OVF(ovf[1]), .OVF_CLR(ovf_clr),
        .NMI(nmi[1]), .IRQ(irq[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: each channel is an ordered list, head at index 0.
    int         dep [2] = '{1, 4};
    bit         owp [2] = '{1'b1, 1'b0};
    logic [7:0] mq  [2][4][16];
    int         mcnt[2][4];
    logic [3:0] e_ovf  [2];
    logic [7:0] e_sdout[2];
    logic [7:0] e_mdout;
    logic [7:0] rreg [2];
    logic [1:0] e_rnew;
    int         nmi_last[2];
    int         cyc;
    int         nmi_hi  [2];
    int         nmi_rise[2];
    bit         nmi_prev[2];

    function automatic void chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %0h want %0h (t=%0t)", nm, k, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 4; c++) mcnt[k][c] = 0;
            e_ovf[k]    = '0;
            e_sdout[k]  = '0;
            nmi_last[k] = -1000;
        end
        e_mdout = '0;
        rreg[0] = '0;
        rreg[1] = '0;
        e_rnew  = '0;
    endfunction

    // Apply the strobes presented this cycle to the model.
    function automatic void model_step();
        cyc++;
        for (int k = 0; k < 2; k++) begin
            bit acc;
            int c;
            acc = 1'b0;
            if (s_re && mcnt[k][s_rsel] > 0) begin
                c = int'(s_rsel);
                e_sdout[k] = mq[k][c][0];
                for (int e = 0; e < 15; e++) mq[k][c][e] = mq[k][c][e+1];
                mcnt[k][c]--;
            end
            e_ovf[k] = e_ovf[k] & ~ovf_clr;
            if (m_we) begin
                c = int'(m_wsel);
                if (mcnt[k][c] < dep[k]) begin
                    mq[k][c][mcnt[k][c]] = m_din;
                    mcnt[k][c]++;
                    acc = 1'b1;
                end else begin
                    e_ovf[k][c] = 1'b1;
                    if (owp[k]) begin
                        mq[k][c][mcnt[k][c]-1] = m_din;
                        acc = 1'b1;
                    end
                end
            end
            if (acc) nmi_last[k] = cyc + NLEN - 1;
        end
        if (m_re) begin
            e_mdout = rreg[m_rsel];
            e_rnew[m_rsel] = 1'b0;
        end
        if (s_we) begin
            rreg[s_wsel] = s_din;
            e_rnew[s_wsel] = 1'b1;
        end
    endfunction

    function automatic void check_all();
        for (int k = 0; k < 2; k++) begin
            logic [3:0] ep;
            logic [3:0] ef;
            for (int c = 0; c < 4; c++) begin
                ep[c] = (mcnt[k][c] != 0);
                ef[c] = (mcnt[k][c] == dep[k]);
            end
            chk("s_pend", k, 32'(s_pend[k]), 32'(ep));
            chk("m_full", k, 32'(m_full[k]), 32'(ef));
            chk("ovf",    k, 32'(ovf[k]),    32'(e_ovf[k]));
            chk("s_dout", k, 32'(s_dout[k]), 32'(e_sdout[k]));
            chk("m_dout", k, 32'(m_dout[k]), 32'(e_mdout));
            chk("m_rnew", k, 32'(m_rnew[k]), 32'(e_rnew));
            chk("nmi",    k, 32'(nmi[k]),    32'(cyc <= nmi_last[k]));
            chk("irq",    k, 32'(irq[k]),    32'(|ep));
        end
    endfunction

    // One clock: model the strobes, let the DUT take the edge, compare on the falling edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
        for (int k = 0; k < 2; k++) begin
            if (nmi[k]) nmi_hi[k]++;
            if (nmi[k] && !nmi_prev[k]) nmi_rise[k]++;
            nmi_prev[k] = nmi[k];
        end
        m_we = 1'b0; m_re = 1'b0; s_re = 1'b0; s_we = 1'b0; ovf_clr = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr_nmi_stats();
        for (int k = 0; k < 2; k++) begin
            nmi_hi[k] = 0;
            nmi_rise[k] = 0;
            nmi_prev[k] = nmi[k];
        end
    endtask

    task automatic wr(input logic [1:0] ch, input logic [7:0] d);
        m_we = 1'b1; m_wsel = ch; m_din = d;
    endtask

    task automatic pop(input logic [1:0] ch);
        s_re = 1'b1; s_rsel = ch;
    endtask

    initial begin
        rst_n = 1'b0;
        m_we = 1'b0; m_wsel = '0; m_din = '0; m_re = 1'b0; m_rsel = '0;
        s_re = 1'b0; s_rsel = '0; s_we = 1'b0; s_wsel = '0; s_din = '0; ovf_clr = '0;
        cyc = 0;
        model_reset();
        clr_nmi_stats();
        repeat (2) @(negedge clk);
        check_all();
        chk("rst_m_dout", 0, 32'(m_dout[0]), 32'h0);
        chk("rst_nmi",    1, 32'(nmi[1]),    32'h0);
        rst_n = 1'b1;
        idle(2);

        // Defaults: write ch2, pop three cycles later.
        clr_nmi_stats();
        wr(2'd2, 8'h5A); tick();
        chk("lit_pend_ch2", 0, 32'(s_pend[0]), 32'h4);
        idle(2);
        pop(2'd2); tick();
        chk("lit_pop_5a",   0, 32'(s_dout[0]), 32'h5A);
        chk("lit_pend_0",   0, 32'(s_pend[0]), 32'h0);
        idle(20);
        chk("lit_nmi_len",  0, 32'(nmi_hi[0]), 32'd16);

        // Full single-entry channel: replace newest; overflow set beats same-cycle clear.
        wr(2'd0, 8'h11); tick();
        wr(2'd0, 8'h22); ovf_clr = 4'b0001; tick();
        chk("lit_ovf0_set", 0, 32'(ovf[0]), 32'h1);
        pop(2'd0); tick();
        chk("lit_pop_22",   0, 32'(s_dout[0]), 32'h22);
        chk("lit_d4_pop11", 1, 32'(s_dout[1]), 32'h11);
        pop(2'd0); tick();
        chk("lit_hold_22",  0, 32'(s_dout[0]), 32'h22);
        chk("lit_pend0_0",  0, 32'(s_pend[0][0]), 32'h0);
        ovf_clr = 4'b0001; tick();
        chk("lit_ovf0_clr", 0, 32'(ovf[0]), 32'h0);
        idle(20);

        // Depth 4, drop on full: fifth write discarded without NMI reload.
        clr_nmi_stats();
        for (int i = 1; i <= 5; i++) begin
            wr(2'd1, 8'(i)); tick();
            if (i == 4) chk("lit_full1", 1, 32'(m_full[1][1]), 32'h1);
        end
        chk("lit_ovf1", 1, 32'(ovf[1][1]), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            pop(2'd1); tick();
            chk("lit_pop_seq", 1, 32'(s_dout[1]), 32'(i));
        end
        idle(20);
        chk("lit_nmi_drop", 1, 32'(nmi_hi[1]), 32'd19);
        ovf_clr = 4'b0010; tick();

        // Simultaneous write and pop on a full depth-4 channel.
        for (int i = 1; i <= 4; i++) begin
            wr(2'd3, 8'(8'h30 + i)); tick();
        end
        wr(2'd3, 8'hAA); pop(2'd3); tick();
        chk("lit_sim_pop",  1, 32'(s_dout[1]), 32'h31);
        chk("lit_sim_ovf",  1, 32'(ovf[1][3]), 32'h0);
        chk("lit_sim_full", 1, 32'(m_full[1][3]), 32'h1);
        for (int i = 0; i < 4; i++) begin
            pop(2'd3); tick();
        end
        chk("lit_last_aa",  1, 32'(s_dout[1]), 32'hAA);
        ovf_clr = 4'b1000; tick();

        // Reply path.
        s_we = 1'b1; s_wsel = 1'b1; s_din = 8'h7E; tick();
        chk("lit_rnew_set", 0, 32'(m_rnew[0]), 32'h2);
        m_re = 1'b1; m_rsel = 1'b1; tick();
        chk("lit_mdout_7e", 0, 32'(m_dout[0]), 32'h7E);
        chk("lit_rnew_clr", 0, 32'(m_rnew[0]), 32'h0);
        s_we = 1'b1; s_wsel = 1'b1; s_din = 8'h3C; m_re = 1'b1; m_rsel = 1'b1; tick();
        chk("lit_rd_old",   0, 32'(m_dout[0]), 32'h7E);
        chk("lit_rnew_kept",0, 32'(m_rnew[0][1]), 32'h1);
        m_re = 1'b1; m_rsel = 1'b1; tick();
        chk("lit_rd_new",   0, 32'(m_dout[0]), 32'h3C);

        // NMI retrigger: writes at t=0 and t=10 give one continuous 26-cycle pulse.
        idle(20);
        clr_nmi_stats();
        wr(2'd0, 8'h01); tick();
        idle(9);
        wr(2'd0, 8'h02); tick();
        idle(30);
        chk("lit_retrig_len", 0, 32'(nmi_hi[0]),   32'd26);
        chk("lit_retrig_one", 0, 32'(nmi_rise[0]), 32'd1);
        pop(2'd0); tick();
        pop(2'd0); tick();

        // Reset in the middle of an NMI pulse with pending data and an overflow.
        wr(2'd0, 8'h41); tick();
        wr(2'd0, 8'h42); tick();
        wr(2'd2, 8'h99); tick();
        idle(4);
        chk("lit_pre_nmi", 0, 32'(nmi[0]), 32'h1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("lit_rst_nmi",  0, 32'(nmi[0]),    32'h0);
        chk("lit_rst_pend", 1, 32'(s_pend[1]), 32'h0);
        chk("lit_rst_ovf",  0, 32'(ovf[0]),    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
